// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// fetch buffer entry layout and the address range helper.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Last byte of the word at pc lies beyond limit; 33-bit sum so a PC near
  // the top of the address space cannot wrap back into range.
  function automatic logic pc_out_of_range(input logic [ADDR_W-1:0] pc,
                                           input logic [ADDR_W-1:0] limit);
    logic [ADDR_W:0] w_last;
    w_last = {1'b0, pc} + {{(ADDR_W-1){1'b0}}, 2'd3};
    return w_last > {1'b0, limit};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO of fetch entries; the head entry is always
// presented on dout straight from the storage registers.
import fetch_pkg::*;

module fetch_fifo #(
  parameter  int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       din,
  input  logic               pop,
  output fetch_entry_t       dout,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = pop & (r_count != '0);
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign w_push = push & ((r_count < CNT_W'(FIFO_DEPTH)) | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads the combinational instruction
// memory, buffers words and hands {pc, instr} to decode over valid/ready.
import fetch_pkg::*;

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] ADDR_LIMIT = 32'd1500
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fault
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]  r_pc;
  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic             w_fetch_req;
  logic             w_range_err;
  logic             w_misaligned;
  logic             w_pop;
  logic             w_has_room;
  logic             w_push;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_din;
  fetch_entry_t     w_head;

  assign w_fetch_req  = (r_state == ST_RUN) & ~halt & ~redirect_valid;
  assign w_range_err  = pc_out_of_range(r_pc, ADDR_LIMIT);
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_pop        = out_valid & out_ready;
  assign w_has_room   = (w_count < CNT_W'(FIFO_DEPTH)) | w_pop;
  assign w_push       = w_fetch_req & ~w_range_err & w_has_room;

  // Redirect outranks everything; an aligned one also clears a fault and
  // lands in HALTED when halt is held so fetching stays stopped.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      if (w_misaligned) begin
        w_state_nxt = ST_FAULT;
      end else if (halt) begin
        w_state_nxt = ST_HALTED;
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt) begin
            w_state_nxt = ST_HALTED;
          end else if (w_range_err) begin
            w_state_nxt = ST_FAULT;
          end
        end
        ST_HALTED: begin
          if (!halt) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_push) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

  assign w_din.pc    = r_pc;
  assign w_din.instr = imem_data;

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count)
  );

  assign imem_addr = r_pc;
  assign out_valid = (w_count != '0);
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;
  assign fault     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] LIMIT = 32'd1500;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        fault;

  logic [7:0] mem [0:2047];

  int n_cmp  = 0;
  int n_fail = 0;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .ADDR_LIMIT (LIMIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big-endian combinational instruction memory
  always_comb begin
    imem_data = 32'h0;
    if (imem_addr <= 32'd2044) begin
      imem_data = {mem[imem_addr[10:0]], mem[imem_addr[10:0] + 11'd1],
                   mem[imem_addr[10:0] + 11'd2], mem[imem_addr[10:0] + 11'd3]};
    end
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int b;
    if (a > 32'd2044) return 32'h0;
    b = int'(a);
    return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs at the falling edge, let the rising edge happen,
  // then leave the caller 1 time unit past the edge for sampling.
  task automatic step(input logic h, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst_n          = 1'b1;
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    @(posedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic        hlt;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [31:0] ea;
    logic        ef;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic h, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic ev, input logic [31:0] epc,
                     input logic [31:0] ea, input logic ef);
    vec_t v;
    v.rst = rst; v.hlt = h; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ea = ea; v.ef = ef;
    v.ei = ev ? word_at(epc) : 32'h0;
    tbl.push_back(v);
  endtask

  // Reference model: architectural view of the fetch buffer as a queue
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  logic        m_paused;

  task automatic model_reset();
    m_q.delete();
    m_pc     = 32'h0;
    m_fault  = 1'b0;
    m_paused = 1'b0;
  endtask

  task automatic model_step(input logic h, input logic rv, input logic [31:0] rpc, input logic rdy);
    ent_t e;
    if (rv) begin
      m_q.delete();
      m_pc = rpc;
      if (rpc[1:0] != 2'b00) begin
        m_fault = 1'b1;
      end else begin
        m_fault  = 1'b0;
        m_paused = h;
      end
    end else begin
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (!m_fault) begin
        if (!m_paused && !h) begin
          if ({1'b0, m_pc} + 33'd3 > {1'b0, LIMIT}) begin
            m_fault = 1'b1;
          end else if (m_q.size() < 2) begin
            e.pc  = m_pc;
            e.ins = word_at(m_pc);
            m_q.push_back(e);
            m_pc = m_pc + 32'd4;
          end
        end
        m_paused = h;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        h, rv, rdy;
    logic [31:0] rpc;
    int          sel;

    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]}   = 32'h1004_0000;
    {mem[4], mem[5], mem[6], mem[7]}   = 32'h1000_8440;
    {mem[8], mem[9], mem[10], mem[11]} = 32'h2088_0061;

    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    #3;
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_fault", 32'(fault), 32'h0);
    chk("reset_addr",  imem_addr, 32'h0);
    chk("reset_pc",    out_pc, 32'h0);
    chk("reset_instr", out_instr, 32'h0);
    @(posedge clk);

    // rst h rv rpc rdy | ev epc ea ef
    add(1, 0, 0, 32'h0,  1, 1, 32'h0,  32'h4,  0);
    add(0, 0, 0, 32'h0,  1, 1, 32'h4,  32'h8,  0);
    add(0, 0, 0, 32'h0,  1, 1, 32'h8,  32'hC,  0);
    add(1, 0, 0, 32'h0,  0, 1, 32'h0,  32'h4,  0);
    add(0, 0, 0, 32'h0,  0, 1, 32'h0,  32'h8,  0);
    add(0, 0, 0, 32'h0,  0, 1, 32'h0,  32'h8,  0);
    add(0, 0, 0, 32'h0,  0, 1, 32'h0,  32'h8,  0);
    add(0, 0, 0, 32'h0,  0, 1, 32'h0,  32'h8,  0);
    add(0, 0, 0, 32'h0,  1, 1, 32'h4,  32'hC,  0);
    add(0, 0, 0, 32'h0,  1, 1, 32'h8,  32'h10, 0);
    add(0, 0, 0, 32'h0,  0, 1, 32'h8,  32'h10, 0);
    add(0, 0, 1, 32'h14, 0, 0, 32'h0,  32'h14, 0);
    add(0, 0, 0, 32'h0,  1, 1, 32'h14, 32'h18, 0);
    add(0, 0, 1, 32'h6,  1, 0, 32'h0,  32'h6,  1);
    add(0, 0, 0, 32'h0,  1, 0, 32'h0,  32'h6,  1);
    add(0, 0, 0, 32'h0,  1, 0, 32'h0,  32'h6,  1);
    add(0, 0, 1, 32'h0,  1, 0, 32'h0,  32'h0,  0);
    add(0, 0, 0, 32'h0,  1, 1, 32'h0,  32'h4,  0);
    add(0, 1, 0, 32'h0,  0, 1, 32'h0,  32'h4,  0);
    add(0, 1, 0, 32'h0,  1, 0, 32'h0,  32'h4,  0);
    add(0, 0, 0, 32'h0,  1, 0, 32'h0,  32'h4,  0);
    add(0, 0, 0, 32'h0,  1, 1, 32'h4,  32'h8,  0);
    add(0, 1, 1, 32'h20, 1, 0, 32'h0,  32'h20, 0);
    add(0, 0, 0, 32'h0,  1, 0, 32'h0,  32'h20, 0);
    add(0, 0, 0, 32'h0,  1, 1, 32'h20, 32'h24, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      step(tbl[i].hlt, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_addr", i),  imem_addr,      tbl[i].ea);
      chk($sformatf("vec%0d_fault", i), 32'(fault),     32'(tbl[i].ef));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_pc", i),    out_pc,    tbl[i].epc);
        chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].ei);
      end
    end

    // Fetch up to the last legal word, then fault at 1500 and drain
    step(0, 1, 32'h5D8, 0);
    chk("lim_redirect_valid", 32'(out_valid), 32'h0);
    chk("lim_redirect_addr",  imem_addr, 32'h5D8);
    step(0, 0, 32'h0, 0);
    chk("lim_fetch_valid", 32'(out_valid), 32'h1);
    chk("lim_fetch_pc",    out_pc, 32'h5D8);
    chk("lim_fetch_instr", out_instr, word_at(32'h5D8));
    chk("lim_fetch_fault", 32'(fault), 32'h0);
    step(0, 0, 32'h0, 0);
    chk("lim_err_fault", 32'(fault), 32'h1);
    chk("lim_err_pc",    out_pc, 32'h5D8);
    chk("lim_err_addr",  imem_addr, 32'h5DC);
    step(0, 0, 32'h0, 1);
    chk("lim_drain_valid", 32'(out_valid), 32'h0);
    step(0, 0, 32'h0, 1);
    chk("lim_after_valid", 32'(out_valid), 32'h0);
    chk("lim_after_fault", 32'(fault), 32'h1);
    step(0, 1, 32'hFFFF_FFFC, 1);
    chk("top_clear_fault", 32'(fault), 32'h0);
    chk("top_addr",        imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 32'h0, 1);
    chk("top_wrap_fault", 32'(fault), 32'h1);
    chk("top_wrap_valid", 32'(out_valid), 32'h0);

    // Asynchronous reset with a full buffer
    pulse_reset();
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    chk("arst_pre_valid", 32'(out_valid), 32'h1);
    chk("arst_pre_addr",  imem_addr, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_fault", 32'(fault), 32'h0);
    chk("arst_addr",  imem_addr, 32'h0);

    // Randomized run against the reference model
    pulse_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("rnd_addr",  imem_addr, m_pc);
      chk("rnd_fault", 32'(fault), 32'(m_fault));
      if (m_q.size() != 0) begin
        chk("rnd_pc",    out_pc,    m_q[0].pc);
        chk("rnd_instr", out_instr, m_q[0].ins);
      end
      h   = ($urandom_range(0, 9) == 0);
      rv  = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 9);
      if (sel < 6)       rpc = {20'h0, 10'($urandom_range(0, 370)), 2'b00};
      else if (sel == 6) rpc = 32'($urandom_range(0, 1500)) | 32'h1;
      else if (sel < 9)  rpc = 32'd1472 + 32'd4 * 32'($urandom_range(0, 8));
      else               rpc = 32'hFFFF_FFFC;
      rst_n          = 1'b1;
      halt           = h;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      model_step(h, rv, rpc, rdy);
    end
    @(negedge clk);
    chk("rnd_final_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("rnd_final_addr",  imem_addr, m_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
